// File: rtl/vmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vmem_access_ctrl_pkg
//  Brief   : Shared types for the vector-memory access controller: vector and
//            mask words, memory opcodes, controller state encoding and the
//            load-response record.
//  Revision: 1.0  initial release
// ============================================================================
package vmem_access_ctrl_pkg;

    localparam int VEC_LANES  = 8;
    localparam int LANE_W     = 8;
    localparam int VEC_WIDTH  = VEC_LANES * LANE_W;
    localparam int VMEM_TAG_W = 4;

    typedef logic [VEC_WIDTH-1:0] Vector_t;
    typedef logic [VEC_LANES-1:0] Mask_t;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } MemOp_t;

    // Controller state; encoded as plain constants for legacy tooling
    typedef logic [1:0] VmemState_t;
    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_CLR_WAIT = 2'd1;
    localparam logic [1:0] c_ST_CLEAR    = 2'd2;

    typedef struct packed {
        Vector_t                 d0;
        Vector_t                 d1;
        logic [VMEM_TAG_W-1:0]   tag;
    } VmemRsp_t;

endpackage
`default_nettype wire

// File: rtl/vmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : vmem_access_ctrl_if
//  Brief   : Request / tagged-response channel between the vector pipe
//            (master) and the vector-memory access controller (slave).
//  Revision: 1.0  initial release
// ============================================================================
interface vmem_access_ctrl_if
    import vmem_access_ctrl_pkg::*;
#(
    parameter int SIZE_L = 11,
    parameter int TAG_W  = 4
);
    logic               req_valid;
    logic               req_ready;
    MemOp_t             req_op;
    logic [SIZE_L-1:0]  req_addr_a;
    logic [SIZE_L-1:0]  req_addr_b;
    Vector_t            req_data;
    Mask_t              req_strb;
    logic [TAG_W-1:0]   req_tag;

    logic               rsp_valid;
    logic               rsp_ready;
    Vector_t            rsp_d0;
    Vector_t            rsp_d1;
    logic [TAG_W-1:0]   rsp_tag;

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_data, req_strb, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_d0, rsp_d1, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_data, req_strb, req_tag,
        output req_ready,
        output rsp_valid, rsp_d0, rsp_d1, rsp_tag,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/vmem_access_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : vmem_rsp_fifo
//  Brief   : Small in-order FIFO of load responses with occupancy count.
//            Caller guarantees no push when full and no pop when empty.
//  Revision: 1.0  initial release
// ============================================================================
module vmem_rsp_fifo
    import vmem_access_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  VmemRsp_t          i_push_data,
    input  logic              i_pop,
    output VmemRsp_t          o_pop_data,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    VmemRsp_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Storage write; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
endmodule
`default_nettype wire

// File: rtl/vmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : vmem_access_ctrl
//  Brief   : Request-side controller for the dual-read / single-write vector
//            RAM. Issues loads and strobed stores, returns load data in order
//            through a tagged response FIFO, and owns a full-RAM clear sweep.
//  Config  : VMEM_RESET_CLEAR_EN - when defined, reset starts a clear sweep.
//  Revision: 1.0  initial release
// ============================================================================
module vmem_access_ctrl
    import vmem_access_ctrl_pkg::*;
#(
    parameter int SIZE      = 2048,
    parameter int SIZE_L    = $clog2(SIZE),
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
)(
    input  logic               clk,
    input  logic               rst,
    vmem_access_ctrl_if.slave  bus,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic               clr_done,
    output logic [SIZE_L-1:0]  ram_addr0,
    output logic [SIZE_L-1:0]  ram_addr1,
    output logic [SIZE_L-1:0]  ram_waddr,
    output Vector_t            ram_din,
    output Mask_t              ram_strb,
    output logic               ram_wen,
    input  Vector_t            ram_d0,
    input  Vector_t            ram_d1
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [SIZE_L-1:0] c_PTR_LAST = SIZE_L'(SIZE - 1);

    // The response record carries a fixed-width tag field
    if (TAG_W != VMEM_TAG_W) begin : g_tag_chk
        $error("TAG_W must equal VMEM_TAG_W");
    end

    VmemState_t         r_state;
    logic [SIZE_L-1:0]  r_ptr;
    logic               r_inflight;
    logic [TAG_W-1:0]   r_tag;
    logic [SIZE_L-1:0]  r_addr0;
    logic [SIZE_L-1:0]  r_addr1;

    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_run_ok;
    logic               w_load_ok;
    logic               w_ld_acc;
    logic               w_st_acc;
    VmemRsp_t           w_push_data;
    VmemRsp_t           w_pop_data;

    // A load may only go out if its response is guaranteed a FIFO slot;
    // a pop this cycle is not credited until the count updates.
    assign w_run_ok  = !rst && (r_state == c_ST_RUN) && !clr_req;
    assign w_load_ok = w_run_ok &&
                       (({1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight})
                        < (CNT_W + 1)'(RSP_DEPTH));
    assign bus.req_ready = (bus.req_op == MEM_STORE) ? w_run_ok : w_load_ok;
    assign w_ld_acc  = bus.req_valid && bus.req_ready && (bus.req_op == MEM_LOAD);
    assign w_st_acc  = bus.req_valid && bus.req_ready && (bus.req_op == MEM_STORE);

    // Controller state and clear-sweep pointer
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef VMEM_RESET_CLEAR_EN
            r_state <= c_ST_CLEAR;
`else
            r_state <= c_ST_RUN;
`endif
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (clr_req) begin
                        r_state <= c_ST_CLR_WAIT;
                    end
                end
                c_ST_CLR_WAIT: begin
                    if (!r_inflight && w_fifo_empty) begin
                        r_state <= c_ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    r_ptr <= r_ptr + SIZE_L'(1);
                    if (r_ptr == c_PTR_LAST) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    // Track the load whose RAM data arrives next cycle, and hold read addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_addr0    <= '0;
            r_addr1    <= '0;
        end else begin
            r_inflight <= w_ld_acc;
            if (w_ld_acc) begin
                r_tag   <= bus.req_tag;
                r_addr0 <= bus.req_addr_a;
                r_addr1 <= bus.req_addr_b;
            end
        end
    end

    assign ram_addr0 = w_ld_acc ? bus.req_addr_a : r_addr0;
    assign ram_addr1 = w_ld_acc ? bus.req_addr_b : r_addr1;

    // Write port: the sweep owns it while clearing, otherwise accepted stores
    always_comb begin
        ram_wen   = 1'b0;
        ram_waddr = bus.req_addr_a;
        ram_din   = bus.req_data;
        ram_strb  = bus.req_strb;
        if (r_state == c_ST_CLEAR) begin
            ram_wen   = !rst;
            ram_waddr = r_ptr;
            ram_din   = '0;
            ram_strb  = '1;
        end else if (w_st_acc) begin
            ram_wen   = 1'b1;
        end
    end

    assign clr_busy = (r_state != c_ST_RUN);
    assign clr_done = (r_state == c_ST_CLEAR) && (r_ptr == c_PTR_LAST);

    assign w_push_data = '{d0: ram_d0, d1: ram_d1, tag: r_tag};
    assign w_pop       = bus.rsp_valid && bus.rsp_ready;

    vmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign bus.rsp_valid = !w_fifo_empty;
    assign bus.rsp_d0    = w_pop_data.d0;
    assign bus.rsp_d1    = w_pop_data.d1;
    assign bus.rsp_tag   = w_pop_data.tag;
endmodule
`default_nettype wire
